kugelblitz_rewrite_engine: RTL and testbench

- Per-port, frame-aware byte rewrite stage on the 512-bit Ethernet AXI-stream path between the port MAC and the Corundum datapath.
- Generalises the fixed per-beat byte patching to RULE_COUNT independent rules. Each rule is addressed by absolute byte offset within the frame, not by lane within a beat.
- Rule sets update atomically at frame boundaries and the stream is registered.
- One instance per direction per port; config is driven from the kugelblitz AXI-lite register file.

---
 rtl/kugelblitz_rewrite_engine.sv | 177 +++++++++++++++++
 tb/tb_kugelblitz_rewrite_engine.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kugelblitz_rewrite_engine.sv
// Kugelblitz rewrite engine: frame-aware byte patching on an AXI-stream path.
// RULE_COUNT rules address absolute byte offsets within a frame. Rule sets are
// latched at frame start so a frame always sees one consistent rule set.
// Optional per-rule hit statistics: define KUGELBLITZ_REWRITE_STATS_EN.
module kugelblitz_rewrite_engine #(
    parameter int unsigned DATA_WIDTH   = 512,
    parameter int unsigned KEEP_WIDTH   = DATA_WIDTH / 8,
    parameter int unsigned USER_WIDTH   = 1,
    parameter int unsigned RULE_COUNT   = 4,
    parameter int unsigned OFFSET_WIDTH = 14
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0]   s_axis_tkeep,
    input  logic                    s_axis_tvalid,
    output logic                    s_axis_tready,
    input  logic                    s_axis_tlast,
    input  logic [USER_WIDTH-1:0]   s_axis_tuser,
    output logic [DATA_WIDTH-1:0]   m_axis_tdata,
    output logic [KEEP_WIDTH-1:0]   m_axis_tkeep,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic                    m_axis_tlast,
    output logic [USER_WIDTH-1:0]   m_axis_tuser,
    input  logic                    cfg_wr_en,
    input  logic [((RULE_COUNT > 1) ? $clog2(RULE_COUNT) : 1)-1:0] cfg_wr_idx,
    input  logic                    cfg_wr_enable,
    input  logic [OFFSET_WIDTH-1:0] cfg_wr_offset,
    input  logic [7:0]              cfg_wr_data,
    input  logic [7:0]              cfg_wr_mask,
    output logic [31:0]             rewrite_count
`ifdef KUGELBLITZ_REWRITE_STATS_EN
    ,
    input  logic                    stats_clear,
    output logic [RULE_COUNT*16-1:0] rule_hit_count
`endif
);

    localparam int unsigned IDX_W  = (RULE_COUNT > 1) ? $clog2(RULE_COUNT) : 1;
    localparam int unsigned LANE_W = $clog2(KEEP_WIDTH);
    localparam int unsigned BEAT_W = OFFSET_WIDTH - LANE_W;

    typedef struct packed {
        logic                    en;
        logic [OFFSET_WIDTH-1:0] offset;
        logic [7:0]              data;
        logic [7:0]              mask;
    } rule_t;

    rule_t                 pend_q [RULE_COUNT];
    rule_t                 act_q  [RULE_COUNT];
    rule_t                 eff_c  [RULE_COUNT];
    logic [RULE_COUNT-1:0] rule_hit_c;
    logic                  beat_hit_c;
    logic                  beat_sat_c;
    logic                  accept_c;
    logic                  in_frame_q;
    logic                  frame_hit_q;
    logic [BEAT_W-1:0]     beat_cnt_q;
    logic [DATA_WIDTH-1:0] data_c;

    assign s_axis_tready = !m_axis_tvalid || m_axis_tready;
    assign accept_c      = s_axis_tvalid && s_axis_tready;
    assign beat_sat_c    = &beat_cnt_q;
    assign beat_hit_c    = |rule_hit_c;

    // Pending rule bank written by the register file.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < RULE_COUNT; r++) pend_q[r] <= '0;
        end else if (cfg_wr_en) begin
            for (int r = 0; r < RULE_COUNT; r++) begin
                if (cfg_wr_idx == IDX_W'(r)) begin
                    pend_q[r] <= {cfg_wr_enable, cfg_wr_offset, cfg_wr_data, cfg_wr_mask};
                end
            end
        end
    end

    // Rule hits for the beat on the input: frame start uses the pending bank directly.
    always_comb begin
        rule_hit_c = '0;
        for (int r = 0; r < RULE_COUNT; r++) begin
            eff_c[r]      = in_frame_q ? act_q[r] : pend_q[r];
            rule_hit_c[r] = eff_c[r].en
                         && (eff_c[r].offset[OFFSET_WIDTH-1:LANE_W] == beat_cnt_q)
                         && !beat_sat_c
                         && s_axis_tkeep[eff_c[r].offset[LANE_W-1:0]];
        end
    end

    // Byte rewrite; ascending rule order lets the highest index win.
    always_comb begin
        logic [7:0] in_byte;
        logic [7:0] out_byte;
        data_c = '0;
        for (int b = 0; b < KEEP_WIDTH; b++) begin
            in_byte  = s_axis_tdata[b*8 +: 8];
            out_byte = in_byte;
            for (int r = 0; r < RULE_COUNT; r++) begin
                if (rule_hit_c[r] && (eff_c[r].offset[LANE_W-1:0] == LANE_W'(b))) begin
                    out_byte = (in_byte & ~eff_c[r].mask) | (eff_c[r].data & eff_c[r].mask);
                end
            end
            if (!s_axis_tkeep[b]) out_byte = 8'h00;
            data_c[b*8 +: 8] = out_byte;
        end
    end

    // Output register stage with AXI-stream hold on backpressure.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '0;
            m_axis_tlast  <= 1'b0;
            m_axis_tuser  <= '0;
        end else if (accept_c) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= data_c;
            m_axis_tkeep  <= s_axis_tkeep;
            m_axis_tlast  <= s_axis_tlast;
            m_axis_tuser  <= s_axis_tuser;
        end else if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
        end
    end

    // Frame tracking, rule latch at frame start and frame hit accounting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_frame_q    <= 1'b0;
            frame_hit_q   <= 1'b0;
            beat_cnt_q    <= '0;
            rewrite_count <= '0;
            for (int r = 0; r < RULE_COUNT; r++) act_q[r] <= '0;
        end else if (accept_c) begin
            if (!in_frame_q) begin
                for (int r = 0; r < RULE_COUNT; r++) act_q[r] <= pend_q[r];
            end
            in_frame_q <= !s_axis_tlast;
            if (s_axis_tlast) begin
                beat_cnt_q  <= '0;
                frame_hit_q <= 1'b0;
                if (frame_hit_q || beat_hit_c) rewrite_count <= rewrite_count + 32'd1;
            end else begin
                frame_hit_q <= frame_hit_q || beat_hit_c;
                if (!beat_sat_c) beat_cnt_q <= beat_cnt_q + BEAT_W'(1);
            end
        end
    end

`ifdef KUGELBLITZ_REWRITE_STATS_EN
    logic [15:0] hit_cnt_q [RULE_COUNT];

    // Per-rule saturating hit counters; clear wins over increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < RULE_COUNT; r++) hit_cnt_q[r] <= '0;
        end else if (stats_clear) begin
            for (int r = 0; r < RULE_COUNT; r++) hit_cnt_q[r] <= '0;
        end else if (accept_c) begin
            for (int r = 0; r < RULE_COUNT; r++) begin
                if (rule_hit_c[r] && (hit_cnt_q[r] != 16'hFFFF)) hit_cnt_q[r] <= hit_cnt_q[r] + 16'd1;
            end
        end
    end

    // Flatten counters onto the stats port.
    always_comb begin
        rule_hit_count = '0;
        for (int r = 0; r < RULE_COUNT; r++) rule_hit_count[r*16 +: 16] = hit_cnt_q[r];
    end
`endif

endmodule

// File: tb/tb_kugelblitz_rewrite_engine.sv
// Scoreboard bench for kugelblitz_rewrite_engine: a byte-offset frame model
// predicts each output beat; a negedge monitor compares DUT output against it.
module tb_kugelblitz_rewrite_engine;

    localparam int DW  = 512;
    localparam int KW  = DW / 8;
    localparam int RC  = 4;
    localparam int OW  = 14;
    localparam int SAT = (1 << (OW - 6)) - 1;

    logic          clk;
    logic          rst;
    logic [DW-1:0] s_axis_tdata;
    logic [KW-1:0] s_axis_tkeep;
    logic          s_axis_tvalid;
    logic          s_axis_tready;
    logic          s_axis_tlast;
    logic [0:0]    s_axis_tuser;
    logic [DW-1:0] m_axis_tdata;
    logic [KW-1:0] m_axis_tkeep;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic          m_axis_tlast;
    logic [0:0]    m_axis_tuser;
    logic          cfg_wr_en;
    logic [1:0]    cfg_wr_idx;
    logic          cfg_wr_enable;
    logic [OW-1:0] cfg_wr_offset;
    logic [7:0]    cfg_wr_data;
    logic [7:0]    cfg_wr_mask;
    logic [31:0]   rewrite_count;
`ifdef KUGELBLITZ_REWRITE_STATS_EN
    logic             stats_clear;
    logic [RC*16-1:0] rule_hit_count;
`endif

    kugelblitz_rewrite_engine #(
        .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .USER_WIDTH(1), .RULE_COUNT(RC), .OFFSET_WIDTH(OW)
    ) dut (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
        .cfg_wr_en(cfg_wr_en), .cfg_wr_idx(cfg_wr_idx), .cfg_wr_enable(cfg_wr_enable),
        .cfg_wr_offset(cfg_wr_offset), .cfg_wr_data(cfg_wr_data), .cfg_wr_mask(cfg_wr_mask),
        .rewrite_count(rewrite_count)
`ifdef KUGELBLITZ_REWRITE_STATS_EN
        , .stats_clear(stats_clear), .rule_hit_count(rule_hit_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state: rules by absolute byte offset, frame position by beat index.
    typedef struct {
        bit          en;
        int unsigned off;
        bit [7:0]    data;
        bit [7:0]    mask;
    } mrule_t;

    typedef struct {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic          last;
        logic [0:0]    user;
        logic [31:0]   cnt;
    } exp_t;

    // Direct checks evaluated by the monitor: 0 tvalid, 1 rewrite_count,
    // 2 last output byte idx, 3 scoreboard depth, 4 rule hit counter idx.
    typedef struct {
        string       name;
        int          kind;
        int          idx;
        logic [31:0] exp;
    } dchk_t;

    mrule_t      pend [RC];
    mrule_t      act  [RC];
    bit          m_in_frame;
    int          m_beat;
    bit          m_frame_hit;
    logic [31:0] m_count;
    bit [15:0]   m_hits [RC];
    exp_t        exp_q [$];
    dchk_t       dq [$];

    int          checks;
    int          failures;
    bit          rand_rdy;
    bit          last_acc;
    bit          rdy_q [$];

    logic [DW-1:0] last_data;
    logic [DW+KW+1:0] held;
    bit            holding;

    task automatic model_reset();
        for (int r = 0; r < RC; r++) begin
            pend[r] = '{0, 0, 0, 0};
            act[r]  = '{0, 0, 0, 0};
            m_hits[r] = 0;
        end
        m_in_frame = 0; m_beat = 0; m_frame_hit = 0; m_count = 0;
    endtask

    task automatic model_accept(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic l, input logic [0:0] u);
        exp_t     e;
        bit       any;
        bit [7:0] ib;
        bit [7:0] b;
        any = 0;
        if (!m_in_frame) act = pend;
        for (int ln = 0; ln < KW; ln++) begin
            ib = d[ln*8 +: 8];
            b  = ib;
            if (k[ln]) begin
                for (int r = 0; r < RC; r++) begin
                    if (act[r].en && act[r].off == m_beat * KW + ln && m_beat < SAT) begin
                        b = (ib & ~act[r].mask) | (act[r].data & act[r].mask);
                        any = 1;
                        if (m_hits[r] != 16'hFFFF) m_hits[r]++;
                    end
                end
            end else begin
                b = 8'h00;
            end
            e.data[ln*8 +: 8] = b;
        end
        if (l) begin
            if (m_frame_hit || any) m_count++;
            m_frame_hit = 0; m_beat = 0; m_in_frame = 0;
        end else begin
            m_frame_hit = m_frame_hit || any;
            m_beat++;
            m_in_frame = 1;
        end
        e.keep = k; e.last = l; e.user = u; e.cnt = m_count;
        exp_q.push_back(e);
    endtask

    // One clock: model sees the handshake at negedge, inputs change after posedge.
    task automatic cycle();
        @(negedge clk);
        last_acc = s_axis_tvalid && s_axis_tready && !rst;
        if (last_acc) model_accept(s_axis_tdata, s_axis_tkeep, s_axis_tlast, s_axis_tuser);
        if (cfg_wr_en && !rst && cfg_wr_idx < RC)
            pend[cfg_wr_idx] = '{cfg_wr_enable, cfg_wr_offset, cfg_wr_data, cfg_wr_mask};
        @(posedge clk);
        #1;
        cfg_wr_en = 1'b0;
        if (rdy_q.size() != 0) m_axis_tready = rdy_q.pop_front();
        else m_axis_tready = rand_rdy ? ($urandom % 3 != 0) : 1'b1;
    endtask

    task automatic set_cfg(input int idx, input bit en, input int off, input bit [7:0] d, input bit [7:0] m);
        cfg_wr_en = 1'b1; cfg_wr_idx = 2'(idx); cfg_wr_enable = en;
        cfg_wr_offset = OW'(off); cfg_wr_data = d; cfg_wr_mask = m;
    endtask

    task automatic cfg_write(input int idx, input bit en, input int off, input bit [7:0] d, input bit [7:0] m);
        set_cfg(idx, en, off, d, m);
        cycle();
    endtask

    task automatic send_beat(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic l, input logic [0:0] u);
        int n;
        s_axis_tdata = d; s_axis_tkeep = k; s_axis_tlast = l; s_axis_tuser = u;
        s_axis_tvalid = 1'b1;
        n = 0;
        do begin
            cycle();
            n++;
        end while (!last_acc && n < 1000);
        s_axis_tvalid = 1'b0;
        if (!last_acc) begin
            $display("FAIL accept_timeout waited=%0d cycles required<1000", n);
            $fatal(1, "input never accepted");
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || m_axis_tvalid) && n < 500) begin
            cycle();
            n++;
        end
        if (n >= 500) begin
            $display("FAIL drain_timeout pending=%0d required=0", exp_q.size());
            $fatal(1, "output never drained");
        end
    endtask

    task automatic dchk(input string name, input int kind, input int idx, input logic [31:0] exp);
        dchk_t c;
        c.name = name; c.kind = kind; c.idx = idx; c.exp = exp;
        dq.push_back(c);
    endtask

    function automatic logic [DW-1:0] pat(input int base);
        logic [DW-1:0] v;
        for (int b = 0; b < KW; b++) v[b*8 +: 8] = 8'(base + b);
        return v;
    endfunction

    function automatic logic [DW-1:0] rnd_data();
        logic [DW-1:0] v;
        for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Monitor: direct checks, scoreboard pops on handshakes, hold stability on stalls.
    always @(negedge clk) begin
        exp_t        e;
        dchk_t       c;
        logic [31:0] got;
        while (dq.size() != 0) begin
            c = dq.pop_front();
            case (c.kind)
                0: got = 32'(m_axis_tvalid);
                1: got = rewrite_count;
                2: got = 32'(last_data[c.idx*8 +: 8]);
                3: got = 32'(exp_q.size());
`ifdef KUGELBLITZ_REWRITE_STATS_EN
                4: got = 32'(rule_hit_count[c.idx*16 +: 16]);
`endif
                default: got = 32'hDEAD_BEEF;
            endcase
            checks++;
            if (got !== c.exp) begin
                failures++;
                $display("FAIL %s got=%h exp=%h", c.name, got, c.exp);
            end
        end
        if (rst) begin
            holding = 0;
            exp_q.delete();
        end else if (m_axis_tvalid) begin
            if (holding) begin
                checks++;
                if ({m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser} !== held) begin
                    failures++;
                    $display("FAIL hold got=%h exp=%h", {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser}, held);
                end
            end
            if (m_axis_tready) begin
                holding = 0;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL extra_beat got=%h exp=none", m_axis_tdata);
                end else begin
                    e = exp_q.pop_front();
                    if (m_axis_tdata !== e.data) begin
                        failures++;
                        $display("FAIL data got=%h exp=%h", m_axis_tdata, e.data);
                    end
                    checks++;
                    if ({m_axis_tkeep, m_axis_tlast, m_axis_tuser} !== {e.keep, e.last, e.user}) begin
                        failures++;
                        $display("FAIL sideband got=%h/%b/%b exp=%h/%b/%b", m_axis_tkeep, m_axis_tlast,
                                 m_axis_tuser, e.keep, e.last, e.user);
                    end
                    checks++;
                    if (rewrite_count !== e.cnt) begin
                        failures++;
                        $display("FAIL rewrite_count got=%0d exp=%0d", rewrite_count, e.cnt);
                    end
                end
                last_data = m_axis_tdata;
            end else begin
                holding = 1;
                held = {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser};
            end
        end else begin
            holding = 0;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog elapsed=%0t limit=5ms", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        int            len;
        checks = 0; failures = 0; holding = 0; last_data = '0; held = '0;
        rand_rdy = 0; last_acc = 0;
        rst = 1'b1;
        s_axis_tdata = '0; s_axis_tkeep = '0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; s_axis_tuser = '0;
        m_axis_tready = 1'b1;
        cfg_wr_en = 1'b0; cfg_wr_idx = '0; cfg_wr_enable = 1'b0; cfg_wr_offset = '0;
        cfg_wr_data = '0; cfg_wr_mask = '0;
`ifdef KUGELBLITZ_REWRITE_STATS_EN
        stats_clear = 1'b0;
`endif
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        dchk("reset_tvalid", 0, 0, 32'd0);
        dchk("reset_count", 1, 0, 32'd0);
        cycle();

        // Single-rule overwrite, one-cycle latency.
        cfg_write(0, 1, 3, 8'hAA, 8'hFF);
        send_beat(pat(0), '1, 1'b1, 1'b0);
        dchk("latency_tvalid", 0, 0, 32'd1);
        drain();
        dchk("r0_byte3", 2, 3, 32'hAA);
        dchk("r0_byte4", 2, 4, 32'h04);
        dchk("r0_count", 1, 0, 32'd1);

        // Masked rewrite in the second beat.
        cfg_write(1, 1, 70, 8'h0F, 8'h0F);
        send_beat(pat(0), '1, 1'b0, 1'b0);
        d = pat(64);
        d[6*8 +: 8] = 8'hF3;
        send_beat(d, '1, 1'b1, 1'b1);
        drain();
        dchk("r1_beat1_lane6", 2, 6, 32'hFF);
        dchk("r1_beat1_lane5", 2, 5, 32'h45);

        // Priority: highest index wins on a shared byte.
        cfg_write(0, 1, 10, 8'h11, 8'hFF);
        cfg_write(2, 1, 10, 8'h22, 8'hFF);
        send_beat(pat(0), '1, 1'b1, 1'b0);
        drain();
        dchk("prio_byte10", 2, 10, 32'h22);

        // Mid-frame retarget only takes effect at the next frame.
        cfg_write(0, 1, 3, 8'hAA, 8'hFF);
        cfg_write(2, 0, 0, 8'h00, 8'h00);
        send_beat(pat(0), '1, 1'b0, 1'b0);
        set_cfg(0, 1, 5, 8'hAA, 8'hFF);
        send_beat(pat(64), '1, 1'b0, 1'b0);
        send_beat(pat(128), '1, 1'b1, 1'b0);
        send_beat(pat(0), '1, 1'b1, 1'b0);
        drain();
        dchk("retarget_byte5", 2, 5, 32'hAA);
        dchk("retarget_byte3", 2, 3, 32'h03);

        // Output backpressure pattern 1,0,0,1 across a 4-beat frame.
        rdy_q = '{1'b1, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) send_beat(pat(i * 64), '1, 1'(i == 3), 1'(i));
        drain();

        // Beat counter saturation: beat 254 rewrites, beat 255 does not.
        cfg_write(3, 1, 254 * 64 + 1, 8'h5A, 8'hFF);
        cfg_write(1, 1, 255 * 64 + 2, 8'hC3, 8'hFF);
        for (int i = 0; i < 256; i++) send_beat(pat(i), '1, 1'(i == 255), 1'b0);
        drain();
        dchk("sat_beat255_byte2", 2, 2, 32'h01);

        // Randomized frames, keeps, rule writes and backpressure.
        rand_rdy = 1;
        for (int f = 0; f < 60; f++) begin
            len = $urandom_range(1, 4);
            for (int b = 0; b < len; b++) begin
                if ($urandom % 4 == 0)
                    set_cfg($urandom % RC, 1'($urandom % 4 != 0),
                            ($urandom % 8 == 0) ? $urandom_range(0, 16383) : $urandom_range(0, 255),
                            8'($urandom), 8'($urandom));
                k = ($urandom % 2 == 0) ? '1 : KW'({$urandom, $urandom});
                send_beat(rnd_data(), k, 1'(b == len - 1), 1'($urandom));
                if ($urandom % 4 == 0) cycle();
            end
        end
        rand_rdy = 0;
        drain();
`ifdef KUGELBLITZ_REWRITE_STATS_EN
        for (int r = 0; r < RC; r++) dchk("hit_counter", 4, r, 32'(m_hits[r]));
        cycle();
`endif

        // Reset mid-frame: held beat dropped, rules and count cleared.
        cfg_write(0, 1, 3, 8'hAA, 8'hFF);
        send_beat(pat(0), '1, 1'b0, 1'b0);
        m_axis_tready = 1'b0;
        rst = 1'b1;
        model_reset();
        dchk("midreset_tvalid", 0, 0, 32'd0);
        cycle();
        cycle();
        rst = 1'b0;
        dchk("midreset_count", 1, 0, 32'd0);
        cycle();
        send_beat(pat(0), '1, 1'b1, 1'b0);
        drain();
        dchk("postreset_byte3", 2, 3, 32'h03);
        dchk("postreset_count", 1, 0, 32'd0);
        dchk("scoreboard_empty", 3, 0, 32'd0);
        cycle();
        cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
